// File: rtl/ir.sv
// SRC instruction register: latches an instruction word from the shared CPU bus,
// decodes its fields and can drive the sign-extended c1/c2 constants back onto the bus.
module ir #(
   parameter int w = 32
) (
   input  logic         clk,
   input  logic         rst,
   inout  wire  [w-1:0] bus,
   input  logic         c1,
   input  logic         c2,
   input  logic         IRin,
   output logic         to_control_unit,
   output logic [4:0]   op,
   output logic [4:0]   ra,
   output logic [4:0]   rb,
   output logic [4:0]   rc,
   output logic [11:0]  c3,
   output logic [2:0]   cond
);

   logic [w-1:0] ir_reg;
   logic [w-1:0] c1_value;
   logic [w-1:0] c2_value;

   // Bus is sampled unfiltered; a load while c1/c2 drive simply captures our own constant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_reg          <= '0;
         to_control_unit <= 1'b0;
      end else if (IRin) begin
         ir_reg          <= bus;
         to_control_unit <= 1'b1;
      end
   end

   assign op   = ir_reg[31:27];
   assign ra   = ir_reg[26:22];
   assign rb   = ir_reg[21:17];
   assign rc   = ir_reg[16:12];
   assign c3   = ir_reg[11:0];
   assign cond = ir_reg[2:0];

   assign c1_value = {{(w-22){ir_reg[21]}}, ir_reg[21:0]};
   assign c2_value = {{(w-17){ir_reg[16]}}, ir_reg[16:0]};

   // c1 takes priority so this block never drives two values at once
   assign bus = c1 ? c1_value : (c2 ? c2_value : {w{1'bz}});

endmodule

// File: tb/tb_ir.sv
// Randomized self-checking bench for ir: a word-level model of the register
// and its field/constant views is compared against the DUT each cycle.
module tb_ir;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        c1 = 1'b0;
   logic        c2 = 1'b0;
   logic        IRin = 1'b0;
   logic        tb_en = 1'b0;
   logic [31:0] tb_data = '0;
   wire  [31:0] bus;
   logic        to_control_unit;
   logic [4:0]  op, ra, rb, rc;
   logic [11:0] c3;
   logic [2:0]  cond;

   int          assertCount = 0;
   int          failCount = 0;
   logic [31:0] modelIr = '0;
   logic        modelValid = 1'b0;

   assign bus = tb_en ? tb_data : 32'bz;

   ir #(.w(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .c1(c1), .c2(c2), .IRin(IRin),
      .to_control_unit(to_control_unit), .op(op), .ra(ra), .rb(rb), .rc(rc),
      .c3(c3), .cond(cond)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Constants treated as signed integers of 22 and 17 bits, widened arithmetically
   function automatic logic [31:0] sext(input logic [31:0] word, input int bits);
      int v;
      v = int'(word % (32'd1 << bits));
      if (v >= (1 << (bits - 1))) v = v - (1 << bits);
      return 32'(v);
   endfunction

   task automatic checkFields(input string tag);
      checkOutput({tag, ".valid"}, 32'(to_control_unit), 32'(modelValid));
      checkOutput({tag, ".op"},   32'(op),   modelIr / (32'd1 << 27));
      checkOutput({tag, ".ra"},   32'(ra),   (modelIr / (32'd1 << 22)) % 32);
      checkOutput({tag, ".rb"},   32'(rb),   (modelIr / (32'd1 << 17)) % 32);
      checkOutput({tag, ".rc"},   32'(rc),   (modelIr / (32'd1 << 12)) % 32);
      checkOutput({tag, ".c3"},   32'(c3),   modelIr % 4096);
      checkOutput({tag, ".cond"}, 32'(cond), modelIr % 8);
   endtask

   // One cycle: drive at negedge, check bus constant, clock, then check fields
   task automatic applyStimulus(input string tag, input logic load, input logic d1,
                                input logic d2, input logic [31:0] data);
      logic [31:0] busExp;
      IRin = load; c1 = d1; c2 = d2;
      tb_en = !(d1 || d2);
      tb_data = data;
      busExp = d1 ? sext(modelIr, 22) : (d2 ? sext(modelIr, 17) : data);
      #1;
      checkOutput({tag, ".bus"}, bus, busExp);
      @(posedge clk);
      if (load) begin
         modelIr = busExp;
         modelValid = 1'b1;
      end
      @(negedge clk);
      checkFields(tag);
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkFields("reset");
      rst = 1'b0;

      applyStimulus("load55", 1'b1, 1'b0, 1'b0, 32'h5555_5555);
      checkOutput("load55.opConst", 32'(op), 32'h0A);
      checkOutput("load55.raConst", 32'(ra), 32'h15);
      checkOutput("load55.c3Const", 32'(c3), 32'h555);
      applyStimulus("c1of55", 1'b0, 1'b1, 1'b0, 32'h0);
      c1 = 1'b1; c2 = 1'b0; tb_en = 1'b0; IRin = 1'b0; #1;
      checkOutput("c1of55.const", bus, 32'h0015_5555);
      c1 = 1'b0; c2 = 1'b1; #1;
      checkOutput("c2of55.const", bus, 32'hFFFF_5555);
      applyStimulus("loadAA", 1'b1, 1'b0, 1'b0, 32'hAAAA_AAAA);
      c1 = 1'b1; c2 = 1'b0; tb_en = 1'b0; #1;
      checkOutput("c1ofAA.const", bus, 32'hFFEA_AAAA);
      c1 = 1'b0; c2 = 1'b1; #1;
      checkOutput("c2ofAA.const", bus, 32'h0000_AAAA);
      c1 = 1'b1; c2 = 1'b1; #1;
      checkOutput("c1c2ofAA.const", bus, 32'hFFEA_AAAA);
      c1 = 1'b0; c2 = 1'b0;
      applyStimulus("hold", 1'b0, 1'b0, 1'b0, 32'h1234_5678);
      applyStimulus("selfLoad", 1'b1, 1'b0, 1'b1, 32'h0);

      // Reset between edges must clear the register without waiting for a clock
      applyStimulus("preRst", 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
      tb_en = 1'b0; IRin = 1'b0; c1 = 1'b1;
      #2 rst = 1'b1;
      modelIr = '0;
      modelValid = 1'b0;
      #1;
      checkFields("asyncRst");
      checkOutput("asyncRst.c1bus", bus, 32'h0);
      @(negedge clk);
      rst = 1'b0; c1 = 1'b0;

      for (int i = 0; i < 300; i++) begin
         logic [1:0] sel;
         sel = 2'($urandom_range(0, 3));
         applyStimulus("rand", ($urandom_range(0, 2) != 0), sel == 2'd1 || sel == 2'd3,
                       sel == 2'd2 || sel == 2'd3, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
